hdb3_txctl: RTL and testbench
=============================

HDB3_TXCTL -- requirements
Module: hdb3_txctl

Interface
REQ-001 Parameter CNTW, default 16: width of the substitution counter.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  system clock; all state changes on the rising edge.
REQ-004 rst  in  1  asynchronous active-low reset; rst=0 forces the reset state immediately.
REQ-005 ien  in  1  line-bit strobe; at most one line bit per cycle with ien=1.
REQ-006 serin  in  1  serial NRZ data bit, sampled only when ien=1.
REQ-007 hdb3en  in  1  1 = HDB3 substitution, 0 = plain AMI; sampled when ien=1.
REQ-008 aisins  in  1  1 = replace serin by 1 (AIS, all-ones); sampled when ien=1.
REQ-009 cntclr  in  1  synchronous clear of subcnt.
REQ-010 opos  out  1  positive-pulse output, registered.
REQ-011 oneg  out  1  negative-pulse output, registered; opos and oneg never both 1.
REQ-012 subcnt  out  CNTW  count of HDB3 substitutions (V insertions), saturating.

Function
REQ-013 A 4-stage window d3..d0 SHALL hold symbol codes: ZERO, ONE, B or V. d0 is newest, d3 oldest.
REQ-014 Effective input bit b = serin | aisins.
REQ-015 On each cycle with ien=1, in this order:
  (a) Emit the symbol in d3.
  (b) Shift d2->d3, d1->d2, d0->d1.
  (c) Load d0 = ONE if b=1, else ZERO.
  (d) Run the substitution check (REQ-018).
REQ-016 Cycles with ien=0 SHALL change no state; opos/oneg hold their value.
REQ-017 Emission: ZERO -> opos=0, oneg=0. ONE or B -> polarity opposite to lastpol. V -> same polarity as lastpol. Every pulse updates lastpol to its polarity.
REQ-018 Substitution check: if hdb3en=1 and d3..d0 (after shift/load) are all ZERO, then:
  - If pcnt is even: d3 := B and d0 := V.
  - If pcnt is odd: d0 := V only.
  - subcnt increments.
REQ-019 pcnt is a 1-bit parity of pulses emitted since the last V.
  - Toggles on each emitted ONE or B.
  - Clears to 0 on each emitted V.
  - REQ-018 uses pcnt after the update from the current emission.
REQ-020 A substituted window SHALL NOT be re-examined; codes V/B are non-ZERO, so overlapping substitution is impossible.
REQ-021 Latency: the bit sampled at strobe k SHALL appear on opos/oneg from the clock edge of strobe k+4 until strobe k+5.
REQ-022 A change of hdb3en SHALL affect only the check at that strobe. Symbols already marked B/V SHALL still be emitted as B/V.
REQ-023 subcnt SHALL saturate at 2^CNTW-1.
  - cntclr=1 clears subcnt to 0.
  - cntclr wins over a simultaneous increment.
  - cntclr acts regardless of ien.
REQ-024 In AMI mode (hdb3en=0) the output SHALL be pure AMI with no violations.

Reset
REQ-025 On rst=0 the block SHALL set:
  - d3..d0 = ZERO
  - opos = 0, oneg = 0
  - lastpol = negative, so the first pulse after reset is positive
  - pcnt = 0
  - subcnt = 0
REQ-026 Reset mid-stream SHALL discard all pending window symbols. Output after release SHALL be as after power-up.

Verification
REQ-027 HDB3, serin=0 continuously after reset -> the first 4 output strobes are 0 (pipeline fill), then repeating groups: +,0,0,+ then -,0,0,- alternating (B00V each time); subcnt +1 per group.
REQ-028 HDB3, input 1,0,0,0,0 then 0s -> output +,0,0,0,+ (000V, V same polarity as the preceding +). Next group is -,0,0,- ; subcnt=2.
REQ-029 AMI (hdb3en=0), input 1,0,0,0,0,0,1,1 -> output +,0,0,0,0,0,-,+ ; subcnt stays 0.
REQ-030 aisins=1 with serin=0, either mode -> output alternates +,-,+,- on every strobe; no substitution occurs.
REQ-031 ien pulsed every 8th cycle with random serin -> opos/oneg change only on strobe edges. The output equals the ien=1-every-cycle reference sequence, delayed 4 strobes.
REQ-032 Assert rst mid-stream while d0..d3 hold a B00V group -> outputs go to 0 immediately; the first post-release pulse is +. With CNTW=4 and 20 substitutions, subcnt=15. cntclr coincident with an increment leaves subcnt=0.

Source files
------------

// File: rtl/hdb3_txctl.sv
// HDB3 / AMI line-code transmitter: 4-symbol look-ahead window with B00V / 000V
// substitution, alternating-mark pulse generation and a saturating substitution counter.
module hdb3_txctl #(
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ien,
   input  logic            serin,
   input  logic            hdb3en,
   input  logic            aisins,
   input  logic            cntclr,
   output logic            opos,
   output logic            oneg,
   output logic [CNTW-1:0] subcnt
);

   typedef enum logic [1:0] {
      SYM_ZERO = 2'd0,
      SYM_ONE  = 2'd1,
      SYM_B    = 2'd2,
      SYM_V    = 2'd3
   } sym_t;

   sym_t            d3_r, d2_r, d1_r, d0_r;
   sym_t            n3_s, n2_s, n1_s, n0_s;
   logic            lastpol_r;
   logic            pcnt_r;
   logic            pcnt_s;
   logic [1:0]      fill_r;
   logic            pulse_s;
   logic            pol_s;
   logic            bit_s;
   logic            subst_s;
   logic            opos_r;
   logic            oneg_r;
   logic [CNTW-1:0] subcnt_r;

   function automatic logic run_of_zeros(input sym_t a, input sym_t b, input sym_t c,
                                         input logic newbit);
      return (a == SYM_ZERO) && (b == SYM_ZERO) && (c == SYM_ZERO) && !newbit;
   endfunction

   // Emission of the oldest symbol: pulse polarity and pulse-parity update
   always_comb begin
      pulse_s = 1'b0;
      pol_s   = lastpol_r;
      pcnt_s  = pcnt_r;
      case (d3_r)
         SYM_ONE, SYM_B: begin
            pulse_s = 1'b1;
            pol_s   = ~lastpol_r;
            pcnt_s  = ~pcnt_r;
         end
         SYM_V: begin
            pulse_s = 1'b1;
            pol_s   = lastpol_r;
            pcnt_s  = 1'b0;
         end
         default: begin
            pulse_s = 1'b0;
            pol_s   = lastpol_r;
            pcnt_s  = pcnt_r;
         end
      endcase
   end

   // Window shift/load and substitution; the window is only examined once it
   // holds four real line bits, so the reset-filled zeros never trigger a B00V.
   always_comb begin
      bit_s   = serin | aisins;
      n3_s    = d2_r;
      n2_s    = d1_r;
      n1_s    = d0_r;
      n0_s    = bit_s ? SYM_ONE : SYM_ZERO;
      subst_s = hdb3en && (fill_r == 2'd3) && run_of_zeros(d2_r, d1_r, d0_r, bit_s);
      if (subst_s) begin
         n0_s = SYM_V;
         if (pcnt_s == 1'b0) begin
            n3_s = SYM_B;
         end else begin
            n3_s = d2_r;
         end
      end else begin
         n0_s = bit_s ? SYM_ONE : SYM_ZERO;
         n3_s = d2_r;
      end
   end

   // Window, line outputs and polarity state; all frozen between strobes
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         d3_r      <= SYM_ZERO;
         d2_r      <= SYM_ZERO;
         d1_r      <= SYM_ZERO;
         d0_r      <= SYM_ZERO;
         opos_r    <= 1'b0;
         oneg_r    <= 1'b0;
         lastpol_r <= 1'b0;
         pcnt_r    <= 1'b0;
         fill_r    <= 2'd0;
      end else if (ien) begin
         d3_r      <= n3_s;
         d2_r      <= n2_s;
         d1_r      <= n1_s;
         d0_r      <= n0_s;
         opos_r    <= pulse_s & pol_s;
         oneg_r    <= pulse_s & ~pol_s;
         lastpol_r <= pol_s;
         pcnt_r    <= pcnt_s;
         if (fill_r != 2'd3) begin
            fill_r <= fill_r + 2'd1;
         end else begin
            fill_r <= fill_r;
         end
      end else begin
         d3_r      <= d3_r;
      end
   end

   // Saturating substitution counter; clear has priority and ignores the strobe
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         subcnt_r <= {CNTW{1'b0}};
      end else if (cntclr) begin
         subcnt_r <= {CNTW{1'b0}};
      end else if (ien && subst_s && (subcnt_r != {CNTW{1'b1}})) begin
         subcnt_r <= subcnt_r + {{(CNTW-1){1'b0}}, 1'b1};
      end else begin
         subcnt_r <= subcnt_r;
      end
   end

   assign opos   = opos_r;
   assign oneg   = oneg_r;
   assign subcnt = subcnt_r;

endmodule

// File: tb/tb_hdb3_txctl.sv
// Directed bench for hdb3_txctl: strobe-by-strobe vector table plus hand-built
// sequences for strobe gating, mid-stream reset and counter saturation/clear.
module tb_hdb3_txctl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ien = 1'b0;
   logic        serin = 1'b0;
   logic        hdb3en = 1'b0;
   logic        aisins = 1'b0;
   logic        cntclr = 1'b0;
   logic        opos, oneg, opos16, oneg16;
   logic [3:0]  subcnt;
   logic [15:0] subcnt16;

   int n_chk  = 0;
   int n_fail = 0;

   hdb3_txctl #(.CNTW(4)) dut (
      .clk(clk), .rst(rst), .ien(ien), .serin(serin), .hdb3en(hdb3en),
      .aisins(aisins), .cntclr(cntclr), .opos(opos), .oneg(oneg), .subcnt(subcnt)
   );

   hdb3_txctl dut16 (
      .clk(clk), .rst(rst), .ien(ien), .serin(serin), .hdb3en(hdb3en),
      .aisins(aisins), .cntclr(cntclr), .opos(opos16), .oneg(oneg16), .subcnt(subcnt16)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic rst_pre;
      logic serin;
      logic aisins;
      logic hdb3en;
      int   out;
      int   sub;
   } vec_t;

   vec_t vecs[$];

   function automatic int polv(input logic p, input logic n);
      return p ? 1 : (n ? -1 : 0);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic s, input logic a, input logic h,
                      input int o, input int sb);
      vec_t v;
      v.rst_pre = r;
      v.serin   = s;
      v.aisins  = a;
      v.hdb3en  = h;
      v.out     = o;
      v.sub     = sb;
      vecs.push_back(v);
   endtask

   task automatic do_reset();
      @(negedge clk);
      ien = 1'b0;
      cntclr = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic strobe(input logic s, input logic a, input logic h, input logic c);
      @(negedge clk);
      serin  = s;
      aisins = a;
      hdb3en = h;
      cntclr = c;
      ien    = 1'b1;
      @(negedge clk);
      ien    = 1'b0;
      cntclr = 1'b0;
   endtask

   initial begin
      // expected line symbols per strobe: +1 positive, -1 negative, 0 none
      int oa[12] = '{0, 0, 0, 0, 1, 0, 0, 1, -1, 0, 0, -1};
      int sa[12] = '{0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3};
      int ob[13] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, -1, 0, 0, -1};
      int sbv[13] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3};
      int ic[12] = '{1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
      int oc[12] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, -1, 1};
      int od[12] = '{0, 0, 0, 0, 1, -1, 1, -1, 1, -1, 1, -1};
      int oe[12] = '{0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0};
      int se[12] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
      int of[12] = '{0, 0, 0, 0, 1, -1, 1, 0, 0, 1, -1, 0};
      int sf[12] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2};
      int prev;

      for (int i = 0; i < 12; i++) add(i == 0, 1'b0, 1'b0, 1'b1, oa[i], sa[i]);
      for (int i = 0; i < 13; i++) add(i == 0, i == 0, 1'b0, 1'b1, ob[i], sbv[i]);
      for (int i = 0; i < 12; i++) add(i == 0, ic[i] != 0, 1'b0, 1'b0, oc[i], 0);
      for (int i = 0; i < 12; i++) add(i == 0, 1'b0, 1'b1, i < 8, od[i], 0);
      for (int i = 0; i < 12; i++) add(i == 0, 1'b0, 1'b0, i < 4, oe[i], se[i]);
      for (int i = 0; i < 12; i++) add(i == 0, i < 2, 1'b0, 1'b1, of[i], sf[i]);

      repeat (3) @(negedge clk);
      chk("reset opos", int'(opos), 0);
      chk("reset oneg", int'(oneg), 0);
      chk("reset subcnt", int'(subcnt), 0);
      rst = 1'b1;

      foreach (vecs[i]) begin
         if (vecs[i].rst_pre) do_reset();
         strobe(vecs[i].serin, vecs[i].aisins, vecs[i].hdb3en, 1'b0);
         chk($sformatf("vec%0d out", i), polv(opos, oneg), vecs[i].out);
         chk($sformatf("vec%0d out16", i), polv(opos16, oneg16), vecs[i].out);
         chk($sformatf("vec%0d subcnt", i), int'(subcnt), vecs[i].sub);
         chk($sformatf("vec%0d excl", i), (opos && oneg) ? 1 : 0, 0);
      end

      // sparse strobes with junk on serin between them: output moves only on strobes
      do_reset();
      prev = 0;
      for (int i = 0; i < 13; i++) begin
         repeat (7) begin
            @(negedge clk);
            serin  = 1'($urandom_range(0, 1));
            hdb3en = 1'($urandom_range(0, 1));
            chk($sformatf("sparse%0d hold", i), polv(opos, oneg), prev);
         end
         strobe(i == 0, 1'b0, 1'b1, 1'b0);
         chk($sformatf("sparse%0d out", i), polv(opos, oneg), ob[i]);
         prev = ob[i];
      end
      chk("sparse subcnt", int'(subcnt), 3);

      // reset while a B00V group sits in the window and a pulse is on the line
      do_reset();
      for (int i = 0; i < 8; i++) strobe(1'b0, 1'b0, 1'b1, 1'b0);
      chk("midrst pre out", polv(opos, oneg), 1);
      rst = 1'b0;
      #1;
      chk("midrst async out", polv(opos, oneg), 0);
      chk("midrst subcnt", int'(subcnt), 0);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) strobe(1'b1, 1'b0, 1'b1, 1'b0);
      chk("midrst fill out", polv(opos, oneg), 0);
      strobe(1'b1, 1'b0, 1'b1, 1'b0);
      chk("midrst first pulse", polv(opos, oneg), 1);

      // 20 substitutions: narrow counter saturates, wide one keeps counting
      do_reset();
      for (int i = 0; i < 80; i++) strobe(1'b0, 1'b0, 1'b1, 1'b0);
      chk("sat subcnt4", int'(subcnt), 15);
      chk("sat subcnt16", int'(subcnt16), 20);
      for (int i = 0; i < 3; i++) strobe(1'b0, 1'b0, 1'b1, 1'b0);
      chk("sat hold subcnt16", int'(subcnt16), 20);
      strobe(1'b0, 1'b0, 1'b1, 1'b1);
      chk("clr vs inc subcnt4", int'(subcnt), 0);
      chk("clr vs inc subcnt16", int'(subcnt16), 0);
      for (int i = 0; i < 4; i++) strobe(1'b0, 1'b0, 1'b1, 1'b0);
      chk("post clr subcnt", int'(subcnt), 1);
      @(negedge clk);
      cntclr = 1'b1;
      @(negedge clk);
      cntclr = 1'b0;
      chk("clr no ien subcnt", int'(subcnt), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
